// File: rtl/mac_st_drain.sv
// mac_st_drain: frames MAC operands into vectors, pulses accu_rst on each first fire, and pushes mac_z into a result FIFO PIPE_LAT cycles after the last fire.
// Stalls op_ready only at vector starts when FIFO occupancy plus in-flight captures reach FIFO_DEPTH; `MAC_DRAIN_TAG_EN adds res_tag.
module mac_st_drain #(
  parameter int ZW         = 20,
  parameter int LEN_W      = 8,
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] len_cfg,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             mac_en,
  output logic             accu_rst,
  input  logic [ZW-1:0]    mac_z,
  output logic             res_valid,
  output logic [ZW-1:0]    res_data,
  input  logic             res_ready
`ifdef MAC_DRAIN_TAG_EN
  ,
  output logic [7:0]       res_tag
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + PIPE_LAT + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t             r_state;
  state_t             w_nxt_state;
  logic [LEN_W-1:0]   r_elem_cnt;
  logic [LEN_W-1:0]   r_len_q;
  logic [LEN_W-1:0]   w_len_eff;
  logic [LEN_W-1:0]   w_elem_inc;
  logic               w_op_ready;
  logic               w_fire;
  logic               w_accu_rst;
  logic               w_cap;

  logic [PIPE_LAT-1:0] r_pipe;
  logic                w_push;
  logic                w_pop;
  logic [CW-1:0]       w_inflight;
  logic [CW-1:0]       w_reserved;

  logic [ZW-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;

  assign w_len_eff  = (len_cfg == '0) ? LEN_W'(1) : len_cfg;
  assign w_elem_inc = r_elem_cnt + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_op_ready  = 1'b0;
    w_fire      = 1'b0;
    w_accu_rst  = 1'b0;
    w_cap       = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          w_op_ready = (w_reserved < DEPTH_C);
          w_fire     = op_valid & w_op_ready;
          if (w_fire) begin
            w_accu_rst = 1'b1;
            if (w_len_eff == LEN_W'(1)) w_cap = 1'b1;
            else                        w_nxt_state = S_ACCUM;
          end
        end
        S_ACCUM: begin
          // The vector start already reserved a FIFO slot, so never stall mid-vector.
          w_op_ready = 1'b1;
          w_fire     = op_valid;
          if (w_fire && (w_elem_inc == r_len_q)) begin
            w_cap       = 1'b1;
            w_nxt_state = S_IDLE;
          end
        end
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  assign op_ready = w_op_ready;
  assign mac_en   = w_fire;
  assign accu_rst = w_accu_rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_elem_cnt <= '0;
      r_len_q    <= '0;
    end else if (w_fire) begin
      if (r_state == S_IDLE) begin
        r_len_q    <= w_len_eff;
        r_elem_cnt <= w_cap ? '0 : LEN_W'(1);
      end else begin
        r_elem_cnt <= w_cap ? '0 : w_elem_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_cap;
      for (int i = 1; i < PIPE_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) w_inflight = w_inflight + CW'(r_pipe[i]);
  end

  assign w_reserved = r_count + w_inflight;
  assign w_push     = r_pipe[PIPE_LAT-1];
  assign w_pop      = (r_count != '0) & res_ready;

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= mac_z;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign res_valid = (r_count != '0);
  assign res_data  = res_valid ? r_mem[r_rd_ptr] : '0;

`ifdef MAC_DRAIN_TAG_EN
  logic [7:0] r_tag_cnt;
  logic [7:0] r_tag_pipe [PIPE_LAT];
  logic [7:0] r_tag_mem  [FIFO_DEPTH];

  // The tag travels beside its capture bit so it lands with the matching z.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_cnt <= '0;
      for (int i = 0; i < PIPE_LAT; i++) r_tag_pipe[i] <= '0;
    end else begin
      if (w_cap) r_tag_cnt <= r_tag_cnt + 8'd1;
      r_tag_pipe[0] <= r_tag_cnt;
      for (int i = 1; i < PIPE_LAT; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_tag_mem[r_wr_ptr] <= r_tag_pipe[PIPE_LAT-1];
  end

  assign res_tag = res_valid ? r_tag_mem[r_rd_ptr] : '0;
`endif

endmodule
